// File: rtl/booth_if.sv
// booth_if: operand/result handshake bundle for booth_radix4_mult
//   master drives start, signed_mode, multiplicand, multiplier
//   slave drives in_ready, product, done, busy
interface booth_if #(parameter int WIDTH = 8);
  logic start;
  logic in_ready;
  logic signed_mode;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [2*WIDTH-1:0] product;
  logic done;
  logic busy;
  modport master(output start, signed_mode, multiplicand, multiplier, input in_ready, product, done, busy);
  modport slave(input start, signed_mode, multiplicand, multiplier, output in_ready, product, done, busy);
endinterface

// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult: sequential radix-4 Booth multiplier, signed/unsigned per operation
//   clk, rst (sync, active-high); bus: booth_if.slave
//     start/in_ready accept, signed_mode + multiplicand + multiplier sampled on accept,
//     product held until next completion, done one-cycle pulse, busy in RUN/DONE
//   optional macro BOOTH_ZERO_SKIP_EN: zero operand bypasses RUN and completes next cycle
module booth_radix4_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH/2+2)
) (
  input logic clk,
  input logic rst,
  booth_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [CNT_W-1:0] N = CNT_W'(WIDTH/2+1);
  logic [1:0] state;
  logic [WIDTH+1:0] m_ext, q;
  logic [WIDTH+2:0] acc, m1, m2, addend, sum;
  logic q_m1, accept, zero;
  logic [CNT_W-1:0] cnt;
  logic [2:0] trip;
  logic [2*WIDTH+5:0] shifted;
  assign bus.in_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign accept = bus.start && bus.in_ready;
`ifdef BOOTH_ZERO_SKIP_EN
  assign zero = bus.multiplicand == '0 || bus.multiplier == '0;
`else
  assign zero = 1'b0;
`endif
  always_comb begin
    trip = {q[1:0], q_m1};
    m1 = {m_ext[WIDTH+1], m_ext};
    m2 = {m_ext, 1'b0};
    addend = (trip == 3'b001 || trip == 3'b010) ? m1 :
             trip == 3'b011 ? m2 :
             trip == 3'b100 ? -m2 :
             (trip == 3'b101 || trip == 3'b110) ? -m1 : '0;
    sum = acc + addend;
    // bit 0 of the shifted register is the new q_m1, so the product sits one bit up
    shifted = $signed({sum, q, q_m1}) >>> 2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.product <= '0;
      bus.done <= 1'b0;
      acc <= '0;
      q <= '0;
      q_m1 <= 1'b0;
      m_ext <= '0;
      cnt <= '0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        m_ext <= bus.signed_mode ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand} : {2'b00, bus.multiplicand};
        q <= bus.signed_mode ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier} : {2'b00, bus.multiplier};
        acc <= '0;
        q_m1 <= 1'b0;
        cnt <= N;
        state <= zero ? DONE : RUN;
        if (zero) begin
          bus.product <= '0;
          bus.done <= 1'b1;
        end
      end else if (state == RUN) begin
        {acc, q, q_m1} <= shifted;
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state <= DONE;
          bus.done <= 1'b1;
          bus.product <= shifted[2*WIDTH:1];
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_booth_radix4_mult.sv
// tb_booth_radix4_mult: randomized and directed checks of 8- and 16-bit Booth multipliers
module tb_booth_radix4_mult;
  logic clk = 0, rst = 1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  booth_if #(.WIDTH(8)) b8();
  booth_if #(.WIDTH(16)) b16();
  booth_radix4_mult #(.WIDTH(8)) u8(.clk(clk), .rst(rst), .bus(b8));
  booth_radix4_mult #(.WIDTH(16)) u16(.clk(clk), .rst(rst), .bus(b16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int w);
    return w == 8 ? b8.in_ready : b16.in_ready;
  endfunction
  function automatic logic dn(input int w);
    return w == 8 ? b8.done : b16.done;
  endfunction
  function automatic logic [31:0] prod(input int w);
    return w == 8 ? {16'd0, b8.product} : b16.product;
  endfunction

  task automatic drive(input int w, input logic s, input logic sm, input logic [15:0] m, input logic [15:0] q);
    if (w == 8) begin
      b8.start = s; b8.signed_mode = sm; b8.multiplicand = m[7:0]; b8.multiplier = q[7:0];
    end else begin
      b16.start = s; b16.signed_mode = sm; b16.multiplicand = m; b16.multiplier = q;
    end
  endtask

  function automatic logic [31:0] ref_mul(input int w, input logic sm, input logic [15:0] m, input logic [15:0] q);
    longint mv, qv;
    if (w == 8) begin
      mv = sm ? longint'($signed(m[7:0])) : longint'(m[7:0]);
      qv = sm ? longint'($signed(q[7:0])) : longint'(q[7:0]);
    end else begin
      mv = sm ? longint'($signed(m)) : longint'(m);
      qv = sm ? longint'($signed(q)) : longint'(q);
    end
    return 32'((mv * qv) & ((64'd1 << (2*w)) - 1));
  endfunction

  function automatic int exp_lat(input int w, input logic [15:0] m, input logic [15:0] q);
    logic [15:0] mask;
    mask = w == 8 ? 16'h00ff : 16'hffff;
    exp_lat = w/2 + 2;
`ifdef BOOTH_ZERO_SKIP_EN
    if ((m & mask) == 0 || (q & mask) == 0) exp_lat = 1;
`else
    if (mask == 0) exp_lat = 0;
`endif
  endfunction

  task automatic do_op(input int w, input logic sm, input logic [15:0] m, input logic [15:0] q,
                       output logic [31:0] p, output int lat);
    int k = 0;
    while (!rdy(w) && k < 50) begin @(posedge clk); #1; k++; end
    drive(w, 1, sm, m, q);
    @(posedge clk); #1;
    drive(w, 0, sm, m, q);
    lat = 1;
    while (!dn(w) && lat < 50) begin @(posedge clk); #1; lat++; end
    p = prod(w);
  endtask

  task automatic op_chk(input string tag, input int w, input logic sm, input logic [15:0] m, input logic [15:0] q);
    logic [31:0] p;
    int lat;
    do_op(w, sm, m, q, p, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(w, m, q)));
    check({tag, "_prod"}, p, ref_mul(w, sm, m, q));
  endtask

  initial begin
    logic [31:0] p;
    int lat;
    logic [15:0] m, q;
    drive(8, 0, 0, 0, 0);
    drive(16, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_prod", prod(8), 0);
    check("rst_done", 32'(b8.done), 0);
    check("rst_ready", 32'(b8.in_ready), 1);
    check("rst_busy", 32'(b8.busy), 0);
    rst = 0;
    @(posedge clk); #1;
    do_op(8, 1, 16'h00fd, 16'h0005, p, lat);
    check("neg3x5", p, 32'h0000fff1);
    check("neg3x5_lat", 32'(lat), 6);
    check("neg3x5_busy", 32'(b8.busy), 1);
    @(posedge clk); #1;
    check("done_width", 32'(b8.done), 0);
    check("hold_prod", prod(8), 32'h0000fff1);
    do_op(8, 1, 16'h0080, 16'h0080, p, lat);
    check("minxmin", p, 32'h00004000);
    do_op(8, 1, 16'h0080, 16'h007f, p, lat);
    check("minxmax", p, 32'h0000c080);
    do_op(8, 0, 16'h00ff, 16'h00ff, p, lat);
    check("ffxff_u", p, 32'h0000fe01);
    do_op(8, 1, 16'h00ff, 16'h00ff, p, lat);
    check("ffxff_s", p, 32'h00000001);
    @(posedge clk); #1;
    drive(8, 1, 0, 16'h0012, 16'h0034);
    @(posedge clk); #1;
    lat = 1;
    while (!b8.done && lat < 50) begin
      check("spam_ready", 32'(b8.in_ready), 0);
      drive(8, 1, $urandom_range(0, 1), 16'($urandom), 16'($urandom));
      @(posedge clk); #1;
      lat++;
    end
    drive(8, 0, 0, 0, 0);
    check("spam_lat", 32'(lat), 6);
    check("spam_prod", prod(8), 32'h000003a8);
    @(posedge clk); #1;
    check("spam_idle", 32'(b8.in_ready), 1);
    check("spam_hold", prod(8), 32'h000003a8);
    drive(8, 1, 0, 16'h0055, 16'h0066);
    @(posedge clk); #1;
    drive(8, 0, 0, 0, 0);
    repeat (2) begin
      check("abort_nodone", 32'(b8.done), 0);
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("abort_prod", prod(8), 0);
    check("abort_done", 32'(b8.done), 0);
    check("abort_ready", 32'(b8.in_ready), 1);
    do_op(8, 0, 16'h0007, 16'h0009, p, lat);
    check("7x9", p, 32'h0000003f);
    check("7x9_lat", 32'(lat), 6);
    op_chk("zero_m", 8, 0, 16'h0000, 16'h005a);
    op_chk("zero_q", 16, 1, 16'h1234, 16'h0000);
    op_chk("min16", 16, 1, 16'h8000, 16'h8000);
    op_chk("ones16", 16, 0, 16'hffff, 16'hffff);
    for (int w = 8; w <= 16; w += 8)
      for (int i = 0; i < 1000; i++) begin
        m = $urandom_range(0, 15) == 0 ? 16'h0 : 16'($urandom);
        q = $urandom_range(0, 15) == 0 ? 16'h0 : 16'($urandom);
        op_chk(w == 8 ? "rnd8" : "rnd16", w, 1'($urandom), m, q);
      end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth_radix4_mult.md
Name: booth_radix4_mult

Overview:
- Sequential radix-4 (modified) Booth multiplier, parametrised in operand width.
- Supports signed and unsigned operands, selected per operation.
- Retires two multiplier bits per cycle and has a start/done handshake with a busy indication.
- Sits in the datapath arithmetic library as the next generation of the radix-2 4-bit sequential Booth multiplier.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4.
- CNT_W, $clog2(WIDTH/2+2), width of the internal iteration counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when in_ready=1.
- in_ready  out  1  high when IDLE; a new operation may be accepted.
- signed_mode  in  1  1 = both operands two's complement; 0 = both unsigned; sampled on accept.
- multiplicand  in  WIDTH  operand M; sampled on accept.
- multiplier  in  WIDTH  operand Q; sampled on accept.
- product  out  2*WIDTH  registered result; holds its value until the next completion.
- done  out  1  one-cycle pulse, coincident with product update.
- busy  out  1  high in RUN and DONE.

Behaviour:
- Reset (synchronous, active-high on clk edge):
  - state=IDLE, product=0, done=0, busy=0, in_ready=1.
  - Internal accumulator and counter are cleared.
  - Reset mid-operation aborts the operation; no done pulse is produced for it.
- States:
  - IDLE -> RUN on start && in_ready.
  - RUN -> DONE when the last iteration is performed.
  - DONE -> IDLE unconditionally after 1 cycle.
- Operand extension on accept:
  - M and Q are extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended otherwise.
  - The extended M is held; ±2M is formed from it at WIDTH+3 bits.
  - The combined register is {acc[WIDTH+2:0], Q_ext[WIDTH+1:0], q_m1}, with acc=0 and q_m1=0 at load.
  - Counter loads N = WIDTH/2+1.
- Each RUN cycle:
  - Recode triplet {Q[1],Q[0],q_m1}: 000/111 -> +0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Add to acc in two's complement, WIDTH+3 bits; wraparound inside acc is impossible by construction.
  - Then arithmetic shift the whole register right by 2.
  - Counter decrements.
- Last iteration (counter==1):
  - product <= low 2*WIDTH bits of the final {acc, Q} value; done <= 1 for exactly the DONE cycle.
  - product must equal the exact mathematical product: signed result in two's complement, unsigned result zero-padded.
- Latency: done is high in the (N+1)th cycle after the accept edge; WIDTH=8 gives done 6 cycles after accept.
- Throughput: one operation per N+2 cycles.
- start is ignored while busy=1, including in the DONE cycle. Operand inputs may change freely while busy.
- in_ready = (state==IDLE); busy = !in_ready.
- Outside the DONE cycle: done=0, and product is unchanged.
- Boundaries: most-negative × most-negative (signed) and all-ones × all-ones (unsigned) must be exact with no overflow. Zero operands take the full latency unless the optional feature is enabled.

Optional Feature:
- Macro: BOOTH_ZERO_SKIP_EN.
- Defined:
  - On accept, if multiplicand==0 or multiplier==0, the FSM goes IDLE -> DONE directly.
  - product=0 and done pulses in the 1st cycle after accept; RUN is bypassed.
  - Non-zero operands behave as without the macro.
- Undefined: no zero detection; all operations take the full N+1-cycle latency.

Test Plan:
- WIDTH=8, signed_mode=1, M=-3 (0xFD), Q=5 -> product=0xFFF1 (-15); done exactly 6 cycles after accept, 1 cycle wide.
- WIDTH=8, signed, M=0x80, Q=0x80 -> product=0x4000 (+16384); then M=0x80, Q=0x7F -> product=0xC080 (-16256).
- WIDTH=8, unsigned, M=0xFF, Q=0xFF -> product=0xFE01; same bit patterns signed -> product=0x0001.
- Start pulsed every cycle with changing operands during RUN/DONE -> only first operation performed; in_ready low until IDLE; product reflects first operands only.
- rst asserted 3 cycles into an operation -> next cycle product=0, done=0, in_ready=1; a fresh 7×9 unsigned op then yields 0x003F with normal latency.
- BOOTH_ZERO_SKIP_EN defined, M=0, Q=0x5A -> done 1 cycle after accept, product=0; undefined -> done after 6 cycles, product=0; randomized 1000-op sweep against reference product for WIDTH=8 and WIDTH=16, both modes.
